// File: rtl/nco_sincos_gen.sv
// Phase-to-amplitude stage: quarter-wave ROM with quadrant symmetry, programmable
// gain with saturation, 4-stage valid/ready pipeline with a single global advance.
module nco_sincos_gen #(
    parameter int unsigned PHASE_WIDTH = 10,
    parameter int unsigned AMP_WIDTH   = 12,
    parameter int unsigned GAIN_WIDTH  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   gain_wr_en,
    input  logic [GAIN_WIDTH-1:0]  gain_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PHASE_WIDTH-1:0] phase_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AMP_WIDTH-1:0]   sin_out,
    output logic [AMP_WIDTH-1:0]   cos_out
);
    localparam int unsigned IDX_W  = PHASE_WIDTH - 2;
    localparam int unsigned DEPTH  = 1 << IDX_W;
    localparam int unsigned MAG_W  = AMP_WIDTH - 1;
    localparam int unsigned PROD_W = AMP_WIDTH + GAIN_WIDTH + 1;

    // Elaboration-time quarter-wave table: round(M*sin(pi*(2k+1)/2^PHASE_WIDTH)),
    // evaluated with a fixed-point (2^30) Taylor series so no real math reaches hardware.
    function automatic logic [DEPTH*MAG_W-1:0] build_rom();
        logic [DEPTH*MAG_W-1:0] rom_v;
        longint one, pi_fix, x, x2, term, acc, amp, m;
        one    = 64'sd1 <<< 30;
        pi_fix = 64'sd3373259426;
        m      = longint'((1 << MAG_W) - 1);
        rom_v  = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            x    = (pi_fix * longint'(2 * k + 1)) / longint'(4 * DEPTH);
            x2   = (x * x) / one;
            term = x;
            acc  = x;
            for (int n = 1; n < 12; n++) begin
                term = -((term * x2) / one) / longint'((2 * n) * (2 * n + 1));
                acc  = acc + term;
            end
            amp = (m * acc + (one >>> 1)) / one;
            rom_v[k*MAG_W +: MAG_W] = MAG_W'(amp);
        end
        return rom_v;
    endfunction

    localparam logic [DEPTH*MAG_W-1:0] ROM_BITS = build_rom();

    // Saturating floor shift of a gain product back to the sample range (+/-M).
    function automatic logic [AMP_WIDTH-1:0] scale_sat(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W-1:0] s;
        logic signed [PROD_W-1:0] lim;
        s   = p >>> (GAIN_WIDTH - 1);
        lim = $signed(PROD_W'((1 << (AMP_WIDTH - 1)) - 1));
        if (s > lim) begin
            return AMP_WIDTH'(lim);
        end else if (s < -lim) begin
            return AMP_WIDTH'(-lim);
        end
        return AMP_WIDTH'(s);
    endfunction

    logic [MAG_W-1:0] rom [DEPTH];

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_rom
        assign rom[g] = ROM_BITS[g*MAG_W +: MAG_W];
    end

    logic                  en;
    logic [GAIN_WIDTH-1:0] gain;
    logic [1:0]            quad;
    logic [IDX_W-1:0]      idx;

    logic                  v1, sin_neg1, cos_neg1;
    logic [IDX_W-1:0]      sin_idx1, cos_idx1;
    logic [GAIN_WIDTH-1:0] gain1;

    logic                  v2, sin_neg2, cos_neg2;
    logic [MAG_W-1:0]      sin_mag2, cos_mag2;
    logic [GAIN_WIDTH-1:0] gain2;

    logic                  v3;
    logic signed [PROD_W-1:0] sin_prod3, cos_prod3;

    logic signed [AMP_WIDTH-1:0]  sin_sgn, cos_sgn;
    logic signed [GAIN_WIDTH:0]   gain_s;

    assign en       = !out_valid || out_ready;
    assign in_ready = rst && en;
    assign quad     = phase_in[PHASE_WIDTH-1 -: 2];
    assign idx      = phase_in[IDX_W-1:0];

    // Gain register: written on any edge, independent of the handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gain <= GAIN_WIDTH'(1 << (GAIN_WIDTH - 1));
        end else if (gain_wr_en) begin
            gain <= gain_in;
        end
    end

    // S1: quadrant decode into sign flags and mirrored ROM indices, gain snapshot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1       <= 1'b0;
            sin_neg1 <= 1'b0;
            cos_neg1 <= 1'b0;
            sin_idx1 <= '0;
            cos_idx1 <= '0;
            gain1    <= '0;
        end else if (en) begin
            v1       <= in_valid;
            sin_neg1 <= quad[1];
            cos_neg1 <= quad[1] ^ quad[0];
            sin_idx1 <= quad[0] ? ~idx : idx;
            cos_idx1 <= quad[0] ? idx : ~idx;
            gain1    <= gain;
        end
    end

    // S2: registered dual ROM read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v2       <= 1'b0;
            sin_neg2 <= 1'b0;
            cos_neg2 <= 1'b0;
            sin_mag2 <= '0;
            cos_mag2 <= '0;
            gain2    <= '0;
        end else if (en) begin
            v2       <= v1;
            sin_neg2 <= sin_neg1;
            cos_neg2 <= cos_neg1;
            sin_mag2 <= rom[sin_idx1];
            cos_mag2 <= rom[cos_idx1];
            gain2    <= gain1;
        end
    end

    assign sin_sgn = sin_neg2 ? -$signed({1'b0, sin_mag2}) : $signed({1'b0, sin_mag2});
    assign cos_sgn = cos_neg2 ? -$signed({1'b0, cos_mag2}) : $signed({1'b0, cos_mag2});
    assign gain_s  = $signed({1'b0, gain2});

    // S3: apply sign and multiply by the unsigned gain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v3        <= 1'b0;
            sin_prod3 <= '0;
            cos_prod3 <= '0;
        end else if (en) begin
            v3        <= v2;
            sin_prod3 <= PROD_W'(sin_sgn) * PROD_W'(gain_s);
            cos_prod3 <= PROD_W'(cos_sgn) * PROD_W'(gain_s);
        end
    end

    // S4: rescale, saturate and register the outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            sin_out   <= '0;
            cos_out   <= '0;
        end else if (en) begin
            out_valid <= v3;
            sin_out   <= scale_sat(sin_prod3);
            cos_out   <= scale_sat(cos_prod3);
        end
    end

endmodule
